// File: rtl/isqrt_pkg.sv
// Shared state type and sizing helpers for the sequential integer square-root unit.
package isqrt_pkg;

  localparam int ISQRT_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } isqrt_state_t;

  // Iteration counter width; never below one bit so the smallest root still gets a counter.
  function automatic int isqrt_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit iteration: brings in two radicand bits and
// decides one root bit. Purely combinational.
module isqrt_step #(
  parameter int N = 16
) (
  input  logic [N+1:0] rem_in,
  input  logic [N-1:0] root_in,
  input  logic [1:0]   bits,
  output logic [N+1:0] rem_out,
  output logic [N-1:0] root_out
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;
  logic         fits;

  // The partial remainder never exceeds twice the partial root, so the top two
  // bits drop out of the shift; the compare still sees the full-width value.
  assign shifted  = {rem_in[N-1:0], bits};
  assign trial    = {root_in, 2'b01};
  assign fits     = {rem_in, bits} >= {2'b00, trial};
  assign rem_out  = fits ? (shifted - trial) : shifted;
  assign root_out = {root_in[N-2:0], fits};

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root, two radicand bits per cycle, start/done handshake.
// Define ISQRT_ROUND_EN to round the root output to nearest (saturating); default is floor.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = ISQRT_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [WIDTH-1:0]     radicand,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     remainder,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = WIDTH / 2;
  localparam int CW = isqrt_cnt_width(N);

  isqrt_state_t  state;
  isqrt_state_t  next_state;
  logic [WIDTH-1:0] rad_sh;
  logic [N+1:0]  p_rem;
  logic [N+1:0]  step_rem;
  logic [N-1:0]  p_root;
  logic [N-1:0]  step_root;
  logic [N-1:0]  final_root;
  logic [CW-1:0] cnt;

  isqrt_step #(.N(N)) u_step (
    .rem_in   (p_rem),
    .root_in  (p_root),
    .bits     (rad_sh[WIDTH-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

`ifdef ISQRT_ROUND_EN
  logic [N:0] root_inc;

  // Round up when the floor remainder exceeds the floor root, clamping at all-ones.
  always_comb begin
    root_inc   = {1'b0, p_root} + (N+1)'(1);
    final_root = p_root;
    if (p_rem > {2'b00, p_root})
      final_root = root_inc[N] ? '1 : root_inc[N-1:0];
  end
`else
  assign final_root = p_root;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (init) next_state = CALC;
      CALC:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad_sh    <= '0;
      p_rem     <= '0;
      p_root    <= '0;
      cnt       <= '0;
      root      <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            rad_sh <= radicand;
            p_rem  <= '0;
            p_root <= '0;
            cnt    <= CW'(N - 1);
          end
        end
        CALC: begin
          p_rem  <= step_rem;
          p_root <= step_root;
          rad_sh <= rad_sh << 2;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        // Results and done are registered together so they appear on the same cycle.
        DONE: begin
          root      <= final_root;
          remainder <= p_rem[N:0];
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: a 32-bit instance for directed/random/reset cases
// and an 8-bit instance swept exhaustively with init held high.
module tb_isqrt_seq;

  localparam int N32 = 16;
  localparam int N8  = 4;

  typedef struct {
    longint root;
    longint rem;
    longint rad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        init32 = 1'b0;
  logic [31:0] rad32  = '0;
  logic [15:0] root32;
  logic [16:0] rem32;
  logic        busy32;
  logic        done32;

  logic        init8 = 1'b0;
  logic [7:0]  rad8  = '0;
  logic [3:0]  root8;
  logic [4:0]  rem8;
  logic        busy8;
  logic        done8;

  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q8[$];

  isqrt_seq #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .init      (init32),
    .radicand  (rad32),
    .root      (root32),
    .remainder (rem32),
    .busy      (busy32),
    .done      (done32)
  );

  isqrt_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .init      (init8),
    .radicand  (rad8),
    .root      (root8),
    .remainder (rem8),
    .busy      (busy8),
    .done      (done8)
  );

  always #5 clk = ~clk;

  // Reference: floor root by binary search on squares, remainder by subtraction.
  function automatic exp_t refModel(input longint x, input int n);
    exp_t   e;
    longint lo;
    longint hi;
    longint mid;
    lo = 0;
    hi = longint'(1) << n;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid;
    end
    e.rad  = x;
    e.root = lo;
    e.rem  = x - lo * lo;
`ifdef ISQRT_ROUND_EN
    if (e.rem > lo) e.root = (lo + 1 > (longint'(1) << n) - 1) ? (longint'(1) << n) - 1 : lo + 1;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one 32-bit operation, optionally poking init/radicand mid-CALC, and time it.
  task automatic applyStimulus(input logic [31:0] v, input bit poke);
    int guard;
    int edges;
    int busy_cycles;
    guard = 0;
    while (busy32 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("idle_before_init32", longint'(guard < 50), 1);
    rad32  = v;
    init32 = 1'b1;
    q32.push_back(refModel(longint'(v), N32));
    @(posedge clk); #1;
    init32      = 1'b0;
    edges       = 0;
    busy_cycles = 0;
    while (!done32 && edges < 40) begin
      if (busy32) busy_cycles++;
      if (poke && edges == 3) begin
        init32 = 1'b1;
        rad32  = 32'd4;
      end else if (poke && edges == 4) begin
        init32 = 1'b0;
        rad32  = v;
      end
      @(posedge clk); #1;
      edges++;
    end
    checkOutput($sformatf("done_latency(rad=%0d)", v), edges, 17);
    checkOutput($sformatf("busy_cycles(rad=%0d)", v), busy_cycles, 17);
  endtask

  always @(negedge clk) begin
    if (!rst && done32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("[TB] FAIL done32_unexpected: got done with 0 pending operations, expected at least 1");
      end else begin
        exp_t e;
        e = q32.pop_front();
        checkOutput($sformatf("root32(rad=%0d)", e.rad), longint'(root32), e.root);
        checkOutput($sformatf("rem32(rad=%0d)", e.rad), longint'(rem32), e.rem);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("[TB] FAIL done8_unexpected: got done with 0 pending operations, expected at least 1");
      end else begin
        exp_t e;
        e = q8.pop_front();
        checkOutput($sformatf("root8(rad=%0d)", e.rad), longint'(root8), e.root);
        checkOutput($sformatf("rem8(rad=%0d)", e.rad), longint'(rem8), e.rem);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_root32", longint'(root32), 0);
    checkOutput("reset_rem32", longint'(rem32), 0);
    checkOutput("reset_busy32", longint'(busy32), 0);
    checkOutput("reset_done32", longint'(done32), 0);
    checkOutput("reset_busy8", longint'(busy8), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(32'd0, 1'b0);
    applyStimulus(32'd1, 1'b0);
    applyStimulus(32'd1000000, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'd90, 1'b0);
    applyStimulus(32'd91, 1'b0);
    applyStimulus(32'd99, 1'b1);

    // Abandon an operation five cycles into CALC; the previous result must be wiped.
    rad32  = 32'd123456;
    init32 = 1'b1;
    @(posedge clk); #1;
    init32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_busy32", longint'(busy32), 0);
    checkOutput("midreset_done32", longint'(done32), 0);
    checkOutput("midreset_root32", longint'(root32), 0);
    checkOutput("midreset_rem32", longint'(rem32), 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("postreset_idle32", longint'(busy32), 0);
    applyStimulus(32'd144, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom, 1'b0);
    end

    // Exhaustive 8-bit sweep with init held high: one acceptance every N+2 cycles.
    init8 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      guard = 0;
      while (busy8 && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      rad8 = 8'(v);
      q8.push_back(refModel(longint'(v), N8));
      @(posedge clk); #1;
      checkOutput($sformatf("accept8(rad=%0d)", v), longint'(busy8), 1);
      if (v > 0) checkOutput($sformatf("interval8(rad=%0d)", v), guard + 1, N8 + 2);
    end
    init8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("pending32", q32.size(), 0);
    checkOutput("pending8", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
